// File: rtl/mem_dirty_range_walker.sv
// -----------------------------------------------------------------------------
// mem_dirty_range_walker
//
// Purpose:
//   This module watches NUM_PORTS memory write ports. It tracks the lowest start
//   byte and the highest end byte written since the last flush or clear, and
//   keeps a saturating count of write strobes. On request it runs a handshaked
//   walk over every word-aligned address in the dirty range. That walk feeds the
//   memory dump path toward debug/UART.
//
// Ports:
//   clk             rising-edge clock for all logic
//   global_flush_i  synchronous active-high reset; has priority over all inputs
//   clear_i         synchronous clear of range and count (walker unaffected)
//   mem_write_en_i  per-port write strobe
//   addr_in_use_i   port p start byte address at [p*ADDR_W +: ADDR_W]
//   size_i          port p log2 access bytes at [2p +: 2] (3 behaves as 2)
//   min_addr_o      lowest byte address written
//   max_addr_o      highest byte address written (last byte of the access)
//   range_valid_o   at least one write since flush/clear
//   write_count_o   write strobes seen, saturating at all-ones
//   dump_start_i    walk request, sampled only while idle
//   dump_valid_o    dump_addr_o holds a beat
//   dump_ready_i    consumer accepts the current beat
//   dump_addr_o     current word-aligned dump address
//   dump_last_o     current beat is the final one
//   dump_busy_o     walker is walking
//   dump_done_o     one-cycle pulse after a walk ends (or an empty request)
// -----------------------------------------------------------------------------
module mem_dirty_range_walker #(
  parameter int ADDR_W     = 32,
  parameter int NUM_PORTS  = 2,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        global_flush_i,
  input  logic                        clear_i,
  input  logic [NUM_PORTS-1:0]        mem_write_en_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_in_use_i,
  input  logic [NUM_PORTS*2-1:0]      size_i,
  output logic [ADDR_W-1:0]           min_addr_o,
  output logic [ADDR_W-1:0]           max_addr_o,
  output logic                        range_valid_o,
  output logic [CNT_W-1:0]            write_count_o,
  input  logic                        dump_start_i,
  output logic                        dump_valid_o,
  input  logic                        dump_ready_i,
  output logic [ADDR_W-1:0]           dump_addr_o,
  output logic                        dump_last_o,
  output logic                        dump_busy_o,
  output logic                        dump_done_o
);

  localparam int PC_W  = $clog2(NUM_PORTS + 1);
  localparam int SUM_W = CNT_W + PC_W;

  localparam logic [ADDR_W-1:0] ADDR_ONES  = '1;
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [SUM_W-1:0]  CNT_MAX    = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WALK = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Per-port start/end addresses
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] port_addr [NUM_PORTS];
  logic [ADDR_W-1:0] port_end  [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [1:0]      eff_size;
    logic [ADDR_W:0] span;
    logic [ADDR_W:0] end_sum;

    assign port_addr[g] = addr_in_use_i[g*ADDR_W +: ADDR_W];
    assign eff_size     = (size_i[2*g +: 2] == 2'd3) ? 2'd2 : size_i[2*g +: 2];
    assign span         = (ADDR_W + 1)'(1) << eff_size;
    // The sum has one extra bit so that an access running past the top of the
    // address space clamps to all-ones and does not wrap to a small address.
    assign end_sum      = {1'b0, port_addr[g]} + span - (ADDR_W + 1)'(1);
    assign port_end[g]  = end_sum[ADDR_W] ? ADDR_ONES : end_sum[ADDR_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // This-cycle reduction over the enabled ports
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] cyc_min;
  logic [ADDR_W-1:0] cyc_max;
  logic              any_en;
  logic [PC_W-1:0]   pop;

  // NOTE: every variable gets a default before the loop, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cyc_min = ADDR_ONES;
    cyc_max = '0;
    any_en  = 1'b0;
    pop     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (mem_write_en_i[p]) begin
        if (port_addr[p] < cyc_min) cyc_min = port_addr[p];
        if (port_end[p]  > cyc_max) cyc_max = port_end[p];
        any_en = 1'b1;
        pop    = pop + PC_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next range and count
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] min_d;
  logic [ADDR_W-1:0] max_d;
  logic              valid_d;
  logic [SUM_W-1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_d;

  always_comb begin
    min_d   = min_addr_o;
    max_d   = max_addr_o;
    valid_d = range_valid_o;
    if (clear_i && !any_en) begin
      min_d   = ADDR_ONES;
      max_d   = '0;
      valid_d = 1'b0;
    end else if (any_en) begin
      // With no tracked range yet, or on a clear, this cycle's writes are the
      // first ones. Their bounds replace the old range and are not merged.
      if (clear_i || !range_valid_o) begin
        min_d = cyc_min;
        max_d = cyc_max;
      end else begin
        min_d = (cyc_min < min_addr_o) ? cyc_min : min_addr_o;
        max_d = (cyc_max > max_addr_o) ? cyc_max : max_addr_o;
      end
      valid_d = 1'b1;
    end
  end

  always_comb begin
    cnt_sum = {PC_W'(0), (clear_i ? CNT_W'(0) : write_count_o)} + {CNT_W'(0), pop};
    cnt_d   = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only. This way every
  // register samples the pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk) begin
    if (global_flush_i) begin
      min_addr_o    <= ADDR_ONES;
      max_addr_o    <= '0;
      range_valid_o <= 1'b0;
      write_count_o <= '0;
    end else begin
      min_addr_o    <= min_d;
      max_addr_o    <= max_d;
      range_valid_o <= valid_d;
      write_count_o <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Walker FSM
  // ---------------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] stop_q;
  logic              done_q;
  logic              at_stop;
  logic              start_ok;
  logic              start_empty;
  logic              beat_fire;

  assign at_stop     = (cur_q == stop_q);
  assign start_ok    = (state_q == S_IDLE) && dump_start_i && range_valid_o;
  assign start_empty = (state_q == S_IDLE) && dump_start_i && !range_valid_o;
  assign beat_fire   = (state_q == S_WALK) && dump_ready_i;

  // State register
  always_ff @(posedge clk) begin
    if (global_flush_i) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_WALK;
      S_WALK:  if (beat_fire && at_stop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Walk datapath. The snapshot comes from the registered range, so a write
  // in the same cycle as the start, or any later write, cannot change a walk
  // that is already running.
  always_ff @(posedge clk) begin
    if (global_flush_i) begin
      cur_q  <= '0;
      stop_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= start_empty || (beat_fire && at_stop);
      if (start_ok) begin
        cur_q  <= min_addr_o & ALIGN_MASK;
        stop_q <= max_addr_o & ALIGN_MASK;
      end else if (beat_fire && !at_stop) begin
        cur_q  <= cur_q + WORD_STEP;
      end
    end
  end

  // Output logic. It depends on state and registers only, so dump_ready_i has
  // no path to dump_valid_o.
  always_comb begin
    dump_valid_o = (state_q == S_WALK);
    dump_busy_o  = (state_q == S_WALK);
    dump_last_o  = (state_q == S_WALK) && at_stop;
    dump_addr_o  = cur_q;
    dump_done_o  = done_q;
  end

endmodule

// File: tb/tb_mem_dirty_range_walker.sv
// -----------------------------------------------------------------------------
// Testbench for mem_dirty_range_walker.
// There are two instances. The main one uses default parameters and the second
// uses CNT_W=2. Both are driven by the same stimulus. A behavioural model
// updates at each rising edge, and one compare process checks both DUTs
// against it on every falling edge. Directed sequences with literal
// expectations come first, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_mem_dirty_range_walker;

  localparam int AW = 32;
  localparam int NP = 2;
  localparam int WB = 4;

  logic            clk = 1'b0;
  logic            flush;
  logic            clear;
  logic [NP-1:0]   en;
  logic [NP*AW-1:0] addr;
  logic [NP*2-1:0] size;
  logic            start;
  logic            ready;

  logic [AW-1:0] min_addr, max_addr, dump_addr;
  logic          range_valid, dump_valid, dump_last, dump_busy, dump_done;
  logic [15:0]   count;

  logic [AW-1:0] s_min_addr, s_max_addr, s_dump_addr;
  logic          s_range_valid, s_dump_valid, s_dump_last, s_dump_busy, s_dump_done;
  logic [1:0]    s_count;

  always #5 clk = ~clk;

  mem_dirty_range_walker dut (
    .clk(clk), .global_flush_i(flush), .clear_i(clear),
    .mem_write_en_i(en), .addr_in_use_i(addr), .size_i(size),
    .min_addr_o(min_addr), .max_addr_o(max_addr), .range_valid_o(range_valid),
    .write_count_o(count), .dump_start_i(start), .dump_valid_o(dump_valid),
    .dump_ready_i(ready), .dump_addr_o(dump_addr), .dump_last_o(dump_last),
    .dump_busy_o(dump_busy), .dump_done_o(dump_done)
  );

  mem_dirty_range_walker #(.CNT_W(2)) dut_small (
    .clk(clk), .global_flush_i(flush), .clear_i(clear),
    .mem_write_en_i(en), .addr_in_use_i(addr), .size_i(size),
    .min_addr_o(s_min_addr), .max_addr_o(s_max_addr), .range_valid_o(s_range_valid),
    .write_count_o(s_count), .dump_start_i(start), .dump_valid_o(s_dump_valid),
    .dump_ready_i(ready), .dump_addr_o(s_dump_addr), .dump_last_o(s_dump_last),
    .dump_busy_o(s_dump_busy), .dump_done_o(s_dump_done)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check task
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: range bounds, counts, and a queue of pending beats
  // ---------------------------------------------------------------------------
  longint unsigned m_min, m_max;
  bit              m_valid;
  longint unsigned m_cnt, m_cnt_s;
  longint unsigned beats[$];
  bit              m_done;

  always @(posedge clk) begin
    bit              nd;
    bit              any;
    longint unsigned cmin, cmax, a, e, sz, pc, base;
    if (flush) begin
      m_min = 64'hFFFF_FFFF; m_max = 0; m_valid = 0;
      m_cnt = 0; m_cnt_s = 0; beats.delete(); m_done = 0;
    end else begin
      nd = 0;
      if (beats.size() > 0) begin
        if (ready) begin
          void'(beats.pop_front());
          if (beats.size() == 0) nd = 1;
        end
      end else if (start) begin
        if (m_valid) begin
          for (longint unsigned w = m_min / WB * WB; w <= m_max / WB * WB; w += WB)
            beats.push_back(w);
        end else begin
          nd = 1;
        end
      end
      m_done = nd;

      any = 0; cmin = 64'hFFFF_FFFF; cmax = 0; pc = 0;
      for (int p = 0; p < NP; p++) begin
        if (en[p]) begin
          a  = addr[p*AW +: AW];
          sz = size[2*p +: 2];
          if (sz == 3) sz = 2;
          e  = a + (64'd1 << sz) - 1;
          if (e > 64'hFFFF_FFFF) e = 64'hFFFF_FFFF;
          if (a < cmin) cmin = a;
          if (e > cmax) cmax = e;
          any = 1; pc++;
        end
      end
      if (clear && !any) begin
        m_min = 64'hFFFF_FFFF; m_max = 0; m_valid = 0; m_cnt = 0; m_cnt_s = 0;
      end else begin
        if (any) begin
          if (clear || !m_valid) begin
            m_min = cmin; m_max = cmax;
          end else begin
            if (cmin < m_min) m_min = cmin;
            if (cmax > m_max) m_max = cmax;
          end
          m_valid = 1;
        end
        base    = clear ? 0 : m_cnt;
        m_cnt   = (base + pc > 65535) ? 65535 : base + pc;
        base    = clear ? 0 : m_cnt_s;
        m_cnt_s = (base + pc > 3) ? 3 : base + pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process, run on every falling edge once reset has been applied
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("min",        64'(min_addr),    m_min);
      check("max",        64'(max_addr),    m_max);
      check("rvalid",     64'(range_valid), 64'(m_valid));
      check("count",      64'(count),       m_cnt);
      check("count_s",    64'(s_count),     m_cnt_s);
      check("dvalid",     64'(dump_valid),  64'(beats.size() > 0));
      check("busy",       64'(dump_busy),   64'(beats.size() > 0));
      check("done",       64'(dump_done),   64'(m_done));
      check("done_s",     64'(s_dump_done), 64'(m_done));
      if (beats.size() > 0) begin
        check("daddr",    64'(dump_addr),   beats[0]);
        check("dlast",    64'(dump_last),   64'(beats.size() == 1));
        check("daddr_s",  64'(s_dump_addr), beats[0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_in();
    flush = 0; clear = 0; start = 0; en = '0;
  endtask

  task automatic put(input int p, input logic [AW-1:0] a, input logic [1:0] s);
    en[p]             = 1'b1;
    addr[p*AW +: AW]  = a;
    size[2*p +: 2]    = s;
  endtask

  task automatic do_flush();
    idle_in(); flush = 1; cyc(); flush = 0;
  endtask

  task automatic setup_words();
    do_flush();
    put(0, 32'h10, 2'd2); put(1, 32'h1C, 2'd2); cyc(); idle_in();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  longint unsigned base_addr;

  initial begin
    idle_in(); ready = 0; addr = '0; size = '0; flush = 1;
    cyc(); chk_en = 1; flush = 0;

    // Reset values
    check("rst_min",   64'(min_addr),    64'hFFFF_FFFF);
    check("rst_max",   64'(max_addr),    64'h0);
    check("rst_rv",    64'(range_valid), 64'h0);
    check("rst_cnt",   64'(count),       64'h0);
    check("rst_valid", 64'(dump_valid),  64'h0);

    // Single word write
    put(0, 32'h100, 2'd2); cyc(); idle_in();
    check("w1_min", 64'(min_addr), 64'h100);
    check("w1_max", 64'(max_addr), 64'h103);
    check("w1_rv",  64'(range_valid), 64'h1);
    check("w1_cnt", 64'(count), 64'h1);

    // Two ports in one cycle, then a clear that also carries a write
    do_flush();
    put(0, 32'h200, 2'd0); put(1, 32'h80, 2'd1); cyc(); idle_in();
    check("w2_min", 64'(min_addr), 64'h80);
    check("w2_max", 64'(max_addr), 64'h200);
    check("w2_cnt", 64'(count), 64'h2);
    clear = 1; put(1, 32'h40, 2'd2); cyc(); idle_in();
    check("clr_min", 64'(min_addr), 64'h40);
    check("clr_max", 64'(max_addr), 64'h43);
    check("clr_cnt", 64'(count), 64'h1);

    // Walk with ready held high
    setup_words();
    start = 1; ready = 1; cyc(); start = 0;
    for (int i = 0; i < 4; i++) begin
      check("walk_valid", 64'(dump_valid), 64'h1);
      check("walk_addr",  64'(dump_addr),  64'(32'h10 + 4 * i));
      check("walk_last",  64'(dump_last),  64'(i == 3));
      check("walk_done",  64'(dump_done),  64'h0);
      cyc();
    end
    check("walk_end_valid", 64'(dump_valid), 64'h0);
    check("walk_end_done",  64'(dump_done),  64'h1);
    cyc();
    check("walk_done_off",  64'(dump_done),  64'h0);

    // Backpressure on the second beat
    setup_words();
    start = 1; ready = 1; cyc(); start = 0;
    check("bp_first", 64'(dump_addr), 64'h10);
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_addr",  64'(dump_addr),  64'h14);
      check("bp_hold_valid", 64'(dump_valid), 64'h1);
      check("bp_hold_last",  64'(dump_last),  64'h0);
      ready = (i == 3);
      cyc();
    end
    check("bp_next", 64'(dump_addr), 64'h18);
    cyc();
    check("bp_last", 64'(dump_last), 64'h1);
    cyc();
    check("bp_done", 64'(dump_done), 64'h1);

    // Start with an empty range
    do_flush();
    start = 1; cyc(); start = 0;
    check("empty_valid", 64'(dump_valid), 64'h0);
    check("empty_busy",  64'(dump_busy),  64'h0);
    check("empty_done",  64'(dump_done),  64'h1);
    cyc();
    check("empty_done_off", 64'(dump_done), 64'h0);

    // End-address clamp at the top of the address space
    put(0, 32'hFFFF_FFFE, 2'd2); cyc(); idle_in();
    check("clamp_max", 64'(max_addr), 64'hFFFF_FFFF);
    check("clamp_min", 64'(min_addr), 64'hFFFF_FFFE);

    // Count saturation in the CNT_W=2 instance
    do_flush();
    for (int i = 0; i < 5; i++) begin
      put(0, 32'h20, 2'd0); cyc();
    end
    idle_in();
    check("sat_small", 64'(s_count), 64'h3);
    check("sat_main",  64'(count),   64'h5);

    // Flush in the middle of a walk
    setup_words();
    start = 1; ready = 1; cyc(); start = 0;
    cyc();
    check("mid_beat2", 64'(dump_addr), 64'h14);
    flush = 1; cyc(); flush = 0;
    check("mid_valid", 64'(dump_valid), 64'h0);
    check("mid_min",   64'(min_addr),   64'hFFFF_FFFF);
    check("mid_max",   64'(max_addr),   64'h0);
    check("mid_cnt",   64'(count),      64'h0);
    for (int i = 0; i < 3; i++) begin
      check("mid_nodone", 64'(dump_done), 64'h0);
      cyc();
    end

    // Randomized run
    base_addr = 0;
    for (int n = 0; n < 4000; n++) begin
      idle_in();
      if ($urandom_range(0, 149) == 0) begin
        flush     = 1;
        base_addr = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FF00 : 64'h0;
      end
      clear = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 9) == 0);
      ready = ($urandom_range(0, 9) < 7);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) == 0)
          put(p, AW'(base_addr + 64'($urandom_range(0, 255))), 2'($urandom_range(0, 3)));
      end
      cyc();
    end
    idle_in(); ready = 1;
    repeat (80) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_dirty_range_walker.md
Name: mem_dirty_range_walker

Overview:
Parametrised successor to the single-port write-range tracker. It watches NUM_PORTS memory write ports and tracks the lowest and highest byte touched since flush, with size-aware end addresses. It also keeps a saturating write count. On request, a handshaked walker emits every word-aligned address in the dirty range, which drives the optimised memory dump to the debug/UART path.

Parameters:
ADDR_W, 32, address width in bits.
NUM_PORTS, 2, number of write ports tracked.
WORD_BYTES, 4, dump stride in bytes; power of two.
CNT_W, 16, width of the write counter.

Ports:
clk  in  1  clock; all logic on rising edge.
global_flush_i  in  1  synchronous active-high reset.
clear_i  in  1  synchronous clear of range and count only; walker unaffected.
mem_write_en_i  in  NUM_PORTS  per-port write strobe.
addr_in_use_i  in  NUM_PORTS*ADDR_W  port p start byte address at [p*ADDR_W +: ADDR_W].
size_i  in  NUM_PORTS*2  port p log2 access bytes at [2p +: 2]: 0=byte, 1=half, 2=word, 3 is treated as 2.
min_addr_o  out  ADDR_W  lowest byte address written.
max_addr_o  out  ADDR_W  highest byte address written (last byte of the access).
range_valid_o  out  1  at least one write since flush/clear.
write_count_o  out  CNT_W  write strobes seen; saturates at all-ones.
dump_start_i  in  1  request a walk; sampled only in IDLE.
dump_valid_o  out  1  dump_addr_o is valid.
dump_ready_i  in  1  consumer accepts the beat.
dump_addr_o  out  ADDR_W  current word-aligned dump address.
dump_last_o  out  1  current beat is the final one.
dump_busy_o  out  1  walker is in WALK.
dump_done_o  out  1  one-cycle pulse when a walk ends.

Behaviour:
- Reset (global_flush_i=1):
  - min_addr_o=all-ones, max_addr_o=0, range_valid_o=0, write_count_o=0.
  - Walker goes to IDLE; dump_valid_o, dump_last_o, dump_busy_o and dump_done_o are all 0.
  - Flush has priority over every other input.
- Per-port end address: end_p = addr_p + (1<<size_p) - 1. If the addition carries out of ADDR_W, end_p clamps to all-ones (no wrap).
- Per cycle, over enabled ports only: cyc_min = min(addr_p), cyc_max = max(end_p).
- Range update, visible the next cycle:
  - If range_valid_o=0 or clear_i=1: min<=cyc_min, max<=cyc_max.
  - Otherwise: min<=min(min,cyc_min), max<=max(max,cyc_max).
  - range_valid_o<=1 whenever any enable is high.
- clear_i with no enables: same result as flush for range and count only.
- clear_i with writes in the same cycle: that cycle's writes become the first writes; count = popcount of enables.
- write_count_o adds the popcount of mem_write_en_i each cycle and saturates at 2^CNT_W-1 (never wraps).
- Walker FSM (IDLE, WALK):
  - IDLE, dump_start_i=1, range_valid_o=1:
    - Snapshot cur = min_addr_o aligned down to WORD_BYTES and stop = max_addr_o aligned down.
    - Move to WALK; first beat appears the next cycle.
    - The snapshot uses registered values; a write in the same cycle is excluded.
  - IDLE, dump_start_i=1, range_valid_o=0: stay in IDLE; pulse dump_done_o the next cycle; no beats.
  - In WALK:
    - dump_valid_o=1, dump_busy_o=1, dump_addr_o=cur, dump_last_o=(cur==stop).
    - On dump_valid_o & dump_ready_i: if last, go to IDLE and pulse dump_done_o the next cycle; else cur<=cur+WORD_BYTES.
    - With ready=1 held, one beat per cycle.
  - Backpressure: while valid & !ready, dump_addr_o and dump_last_o are held stable.
  - dump_start_i during WALK is ignored.
  - Writes and clear_i during WALK update the tracker but not the snapshot.
  - Flush mid-walk: IDLE after the edge, dump_valid_o=0, no done pulse.
- Outputs are registered or derived from state only; there is no combinational path from dump_ready_i to dump_valid_o.

Test Plan:
- Flush, then port0 write 0x100 size2 -> next cycle min=0x100, max=0x103, range_valid=1, count=1.
- Same cycle: port0 0x200 size0 and port1 0x80 size1 -> min=0x80, max=0x200, count=2. Next cycle clear_i with port1 0x40 size2 -> min=0x40, max=0x43, count=1.
- Word writes 0x10 and 0x1C, dump_start with ready=1 -> beats 0x10, 0x14, 0x18, 0x1C on consecutive cycles, first beat one cycle after start, last only on 0x1C, done pulse the cycle after.
- Same setup, ready low for 3 cycles while 0x14 is presented -> 0x14 held with valid=1 and last=0 for 4 cycles, then 0x18 follows.
- dump_start right after flush -> no valid, busy=0, done pulse one cycle later. Separately, write 0xFFFF_FFFE size2 -> max=0xFFFF_FFFF.
- CNT_W=2 with 5 single writes -> count sticks at 3. Flush during WALK at beat 2 -> valid=0 next cycle, min=0xFFFF_FFFF, max=0, count=0, done never asserted.
